cp0_regfile: RTL

//  Coprocessor-0 register file and exception commit stage for the MIPS pipeline.

---
 rtl/cp0_pkg.sv | 51 +++++
 rtl/cp0_timer.sv | 37 +++
 rtl/cp0_regfile.sv | 98 +++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register addresses, excepttype codes and field helpers
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_ERET = 32'hE;

  localparam int STATUS_EXL   = 1;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_HW  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  // Only IM, EXL, IE of Status and the two software IP bits of Cause take MTC0 data
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic exc_valid(input logic [31:0] t);
    case (t)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV: exc_valid = 1'b1;
      default: exc_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] exc_code(input logic [31:0] t);
    case (t)
      EXC_INT:  exc_code = 5'd0;
      EXC_ADEL: exc_code = 5'd4;
      EXC_ADES: exc_code = 5'd5;
      EXC_SYS:  exc_code = 5'd8;
      EXC_BP:   exc_code = 5'd9;
      EXC_RI:   exc_code = 5'd10;
      EXC_OV:   exc_code = 5'd12;
      default:  exc_code = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with half-rate Count and sticky match interrupt
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle    <= 1'b0;
      count     <= 32'h0;
      compare   <= 32'h0;
      timer_int <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (count_we)
        count <= wdata;
      else if (toggle)
        count <= count + 32'd1;
      // A Compare write acknowledges the interrupt even if it matches this cycle
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (count == compare && compare != 32'h0) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file, exception/ERET commit and redirect
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        timer_int_o
);

  logic [31:0] status, cause, epc, badvaddr, count, compare;
  logic        exc_take, is_eret, wr;

  assign exc_take = !rst && exc_valid(excepttype_i);
  assign is_eret  = !rst && (excepttype_i == EXC_ERET);
  assign flush_o  = exc_take || is_eret;
  assign new_pc_o = is_eret ? epc : (exc_take ? EXC_VECTOR : 32'h0);
  // The MTC0 belongs to an instruction being flushed, so it must not land
  assign wr       = we_i && !flush_o;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr && waddr_i == CP0_COUNT),
    .compare_we (wr && waddr_i == CP0_COMPARE),
    .wdata      (wdata_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RST;
      cause    <= 32'h0;
      epc      <= 32'h0;
      badvaddr <= 32'h0;
    end else begin
      cause[CAUSE_IP_HI:CAUSE_IP_HW] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc_take) begin
        if (!status[STATUS_EXL]) begin
          epc             <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
          cause[CAUSE_BD] <= in_delayslot_i;
        end
        status[STATUS_EXL]                <= 1'b1;
        cause[CAUSE_EXC_HI:CAUSE_EXC_LO]  <= exc_code(excepttype_i);
        if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
          badvaddr <= bad_addr_i;
      end else if (is_eret) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (wr) begin
        case (waddr_i)
          CP0_STATUS: status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
          CP0_CAUSE:  cause[9:8] <= wdata_i[9:8];
          CP0_EPC:    epc <= wdata_i;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    if (!rst) begin
      case (raddr_i)
        CP0_BADVADDR: rdata_o = badvaddr;
        CP0_COUNT:    rdata_o = count;
        CP0_COMPARE:  rdata_o = compare;
        CP0_STATUS:   rdata_o = status;
        CP0_CAUSE:    rdata_o = cause;
        CP0_EPC:      rdata_o = epc;
        default:      rdata_o = 32'h0;
      endcase
    end
  end

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;

endmodule
